bootram_ctrl: RTL and testbench
===============================

# bootram_ctrl

Sequencing and arbitration controller for the 2Kx8 single-port boot RAM. It exposes a 32-bit valid/ready word port for the CPU and an optional 8-bit write-only loader port for the UART bootloader. Each word access is serialised into four byte accesses on the RAM, and the two requesters are arbitrated in round-robin. It sits between the SoC bus and the boot RAM macro and drives every RAM control pin.

## Interface
- `RAM_AW`, 11: RAM byte-address width (2048 bytes).
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `mem_valid` in 1: CPU request; held with address/data until `mem_ready`.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_addr` in 32: byte address; bits [RAM_AW-1:2] used, rest ignored (aliases).
- `mem_wdata` in 32: write data, little-endian lanes.
- `mem_wstrb` in 4: byte enables; 4'b0000 means read.
- `mem_rdata` out 32: read data, valid with `mem_ready`.
- `ldr_valid` in 1: loader byte-write request; held until `ldr_ready`.
- `ldr_ready` out 1: one-cycle completion pulse.
- `ldr_addr` in RAM_AW: loader byte address.
- `ldr_wdata` in 8: loader byte.
- `ram_ce`, `ram_wre` out 1: RAM clock enable and write enable.
- `ram_oce` out 1: constant 1.
- `ram_ad` out RAM_AW: RAM byte address.
- `ram_din` out 8: RAM write data.
- `ram_dout` in 8: RAM read data, one cycle after a CE read (bypass mode).

## Operation
- States: IDLE, CPU_RD, CPU_WR, LDR_WR, RESP.
- IDLE: the grant is evaluated each cycle. With a single requester, that requester wins. With both, the winner is the one not granted last. The `last` bit resets to "loader", so the CPU wins the first tie.
- CPU_RD: a 2-bit byte index k runs 0..3. Each cycle drives `ram_ce=1`, `ram_wre=0`, `ram_ad={mem_addr[RAM_AW-1:2],k}`. The `ram_dout` of the previous issue is captured into `mem_rdata[8(k-1)+7:8(k-1)]`. After k=3 the state goes to RESP, which captures byte 3.
- CPU_WR: k runs 0..3. `ram_ce=mem_wstrb[k]`, `ram_wre=1`, `ram_din=mem_wdata[8k+7:8k]`. Strobe-0 lanes consume their cycle without touching the RAM. Then RESP.
- LDR_WR: one cycle with `ram_ce=1`, `ram_wre=1`, `ram_ad=ldr_addr`, `ram_din=ldr_wdata`. Then RESP.
- RESP: pulses the ready of the granted requester for one cycle, then returns to IDLE. The request is not re-sampled in RESP.
- If a requester drops valid mid-transaction, the transaction still completes and ready still pulses.
- Reset mid-operation: state goes to IDLE and all outputs return to reset values. A partially written word is left partially written, and no ready is issued.
- Reset values: `mem_ready=0`, `ldr_ready=0`, `mem_rdata=0`, `ram_ce=0`, `ram_wre=0`, `ram_ad=0`, `ram_din=0`, `ram_oce=1`.

## Timing
- All RAM controls are registered. A grant in cycle A gives the first RAM cycle at A+1.
- CPU read: issues at A+1..A+4; `mem_ready` and the full `mem_rdata` at A+6. Latency is 6 cycles from the first `mem_valid` sample in IDLE.
- CPU write: RAM cycles at A+1..A+4, `mem_ready` at A+5.
- Loader write: RAM cycle at A+1, `ldr_ready` at A+2.
- The minimum gap between back-to-back grants is one IDLE cycle.
- `mem_rdata` holds its value until the next read completes.

## Configuration
- `BOOTRAM_LOADER_EN` defined: loader port and round-robin arbitration as described above.
- `BOOTRAM_LOADER_EN` undefined:
  - LDR_WR is removed and `ldr_valid`/`ldr_addr`/`ldr_wdata` are ignored.
  - `ldr_ready` is tied to 0.
  - The CPU is granted whenever `mem_valid` is high in IDLE.
  - The port list is unchanged.

## Structure
- Shared package `bootram_pkg` holds the state enum, `BYTE_LANES=4`, and the default `RAM_AW=11`.
- One sub-module, `bootram_rr_arb`: two-requester round-robin grant with the `last` register. It is instantiated only under `BOOTRAM_LOADER_EN`.

## Test plan
- **Reset:** hold `reset` for 3 cycles with random inputs → all outputs at reset values, no ready pulse, `ram_oce=1`.
- **Word write then read:** CPU writes 0xDEADBEEF to 0x10 with wstrb 4'b1111 → `ram_ad` steps 0x010..0x013, `mem_ready` at A+5. A read of 0x10 then returns 0xDEADBEEF with `mem_ready` at A+6.
- **Partial write:** wstrb 4'b0010 with wdata 0x0000AA00 at 0x10 → only byte 0x011 is CE'd. A readback gives 0xDEADAAEF.
- **Simultaneous requests:** `ldr_valid` (0x011, 0x55) and a CPU read of 0x10 arrive together after reset → CPU is served first, then the loader. A repeat tie grants the loader first. A final CPU read returns 0xDEAD55EF.
- **Reset mid-read:** assert `reset` at A+3 of a read → no `mem_ready`, `ram_ce=0` the next cycle, and a fresh read afterwards completes normally.
- **Macro off:** build without `BOOTRAM_LOADER_EN` and hold `ldr_valid=1` → `ldr_ready` never asserts and CPU reads keep 6-cycle latency.

Source files
------------

// File: rtl/bootram_pkg.sv
// Shared types and constants for the boot RAM controller slice.
package bootram_pkg;

    localparam int unsigned BYTE_LANES     = 4;
    localparam int unsigned RAM_AW_DEFAULT = 11;

    typedef enum logic [2:0] {
        IDLE,
        CPU_RD,
        CPU_WR,
        LDR_WR,
        RESP
    } state_t;

endpackage

// File: rtl/bootram_rr_arb.sv
// Two-requester round-robin grant (CPU vs. UART loader).
// The 'last' register remembers who was granted most recently; on a tie the
// other requester wins. It resets to "loader" so the CPU wins the first tie.
// Requests are expected to be pre-qualified by the caller (only asserted when
// a grant may actually be taken), so any grant updates 'last'.
module bootram_rr_arb
    import bootram_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_cpu,
    input  logic req_ldr,
    output logic gnt_cpu,
    output logic gnt_ldr
);

    logic last_ldr;

    // Grant decision: single requester wins outright, ties go to the one not granted last.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_ldr = 1'b0;
        if (req_cpu && req_ldr) begin
            gnt_cpu = last_ldr;
            gnt_ldr = !last_ldr;
        end else begin
            gnt_cpu = req_cpu;
            gnt_ldr = req_ldr;
        end
    end

    // Track the most recent winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_ldr <= 1'b1;
        end else if (gnt_cpu) begin
            last_ldr <= 1'b0;
        end else if (gnt_ldr) begin
            last_ldr <= 1'b1;
        end
    end

endmodule

// File: rtl/bootram_ctrl.sv
// Boot RAM sequencer: serialises 32-bit CPU word accesses into four byte
// accesses on the 2Kx8 single-port RAM and, when BOOTRAM_LOADER_EN is
// defined, arbitrates an 8-bit write-only loader port in round-robin.
// Without BOOTRAM_LOADER_EN the loader inputs are ignored and ldr_ready is 0.
module bootram_ctrl
    import bootram_pkg::*;
#(
    parameter int unsigned RAM_AW = RAM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    input  logic              ldr_valid,
    output logic              ldr_ready,
    input  logic [RAM_AW-1:0] ldr_addr,
    input  logic [7:0]        ldr_wdata,
    output logic              ram_ce,
    output logic              ram_wre,
    output logic              ram_oce,
    output logic [RAM_AW-1:0] ram_ad,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout
);

    localparam int unsigned WAW = RAM_AW - 2;

    state_t         state;
    logic [1:0]     k;
    logic           rd_q;
    logic [WAW-1:0] word_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wstrb_q;
    logic [23:0]    rd_shadow;
    logic           ldr_ready_q;
    logic           can_grant;
    logic           gnt_cpu;

    // Address bits outside the RAM word range alias and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:RAM_AW], mem_addr[1:0]};

    assign ram_oce = 1'b1;

    // A ready pulse for a read is presented while already back in IDLE; holding
    // off the grant for that cycle keeps a still-asserted valid from re-granting.
    assign can_grant = (state == IDLE) && !mem_ready && !ldr_ready_q;

`ifdef BOOTRAM_LOADER_EN
    logic gnt_ldr;

    bootram_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_cpu (mem_valid && can_grant),
        .req_ldr (ldr_valid && can_grant),
        .gnt_cpu (gnt_cpu),
        .gnt_ldr (gnt_ldr)
    );

    assign ldr_ready = ldr_ready_q;
`else
    logic unused_ldr;
    assign unused_ldr = ^{ldr_valid, ldr_addr, ldr_wdata};

    assign gnt_cpu   = mem_valid && can_grant;
    assign ldr_ready = 1'b0;
`endif

    // Main sequencer: all RAM controls and ready/rdata are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            k           <= '0;
            rd_q        <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rd_shadow   <= '0;
            mem_ready   <= 1'b0;
            ldr_ready_q <= 1'b0;
            mem_rdata   <= '0;
            ram_ce      <= 1'b0;
            ram_wre     <= 1'b0;
            ram_ad      <= '0;
            ram_din     <= '0;
        end else begin
            mem_ready   <= 1'b0;
            ldr_ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    ram_ce  <= 1'b0;
                    ram_wre <= 1'b0;
                    if (gnt_cpu) begin
                        word_q  <= mem_addr[RAM_AW-1:2];
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        k       <= 2'd0;
                        ram_ad  <= {mem_addr[RAM_AW-1:2], 2'b00};
                        if (mem_wstrb == '0) begin
                            rd_q    <= 1'b1;
                            state   <= CPU_RD;
                            ram_ce  <= 1'b1;
                            ram_wre <= 1'b0;
                        end else begin
                            rd_q    <= 1'b0;
                            state   <= CPU_WR;
                            ram_ce  <= mem_wstrb[0];
                            ram_wre <= 1'b1;
                            ram_din <= mem_wdata[7:0];
                        end
                    end
`ifdef BOOTRAM_LOADER_EN
                    else if (gnt_ldr) begin
                        rd_q    <= 1'b0;
                        state   <= LDR_WR;
                        ram_ce  <= 1'b1;
                        ram_wre <= 1'b1;
                        ram_ad  <= ldr_addr;
                        ram_din <= ldr_wdata;
                    end
`endif
                end

                // k is the byte on the RAM bus this cycle; ram_dout carries byte k-1.
                // Bytes 0..2 go to a shadow so mem_rdata only changes on completion.
                CPU_RD: begin
                    case (k)
                        2'd1:    rd_shadow[7:0]   <= ram_dout;
                        2'd2:    rd_shadow[15:8]  <= ram_dout;
                        2'd3:    rd_shadow[23:16] <= ram_dout;
                        default: ;
                    endcase
                    if (k == 2'd3) begin
                        ram_ce <= 1'b0;
                        state  <= RESP;
                    end else begin
                        k      <= k + 2'd1;
                        ram_ad <= {word_q, k + 2'd1};
                    end
                end

                CPU_WR: begin
                    if (k == 2'd3) begin
                        ram_ce    <= 1'b0;
                        ram_wre   <= 1'b0;
                        mem_ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        k       <= k + 2'd1;
                        ram_ad  <= {word_q, k + 2'd1};
                        ram_ce  <= wstrb_q[k + 2'd1];
                        ram_din <= wdata_q[{k + 2'd1, 3'b000} +: 8];
                    end
                end

`ifdef BOOTRAM_LOADER_EN
                LDR_WR: begin
                    ram_ce      <= 1'b0;
                    ram_wre     <= 1'b0;
                    ldr_ready_q <= 1'b1;
                    state       <= RESP;
                end
`endif

                // Writes already have their ready visible here; reads collect byte 3
                // now and present ready in the following cycle.
                RESP: begin
                    if (rd_q) begin
                        mem_rdata <= {ram_dout, rd_shadow};
                        mem_ready <= 1'b1;
                        rd_q      <= 1'b0;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bootram_ctrl.sv
// Scoreboard bench for bootram_ctrl: a behavioural RAM answers the DUT, a
// byte-array reference model predicts each CPU response, and a negedge
// monitor pops and compares whenever a ready pulse appears.
`timescale 1ns/1ps
module tb_bootram_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        ldr_valid, ldr_ready;
    logic [10:0] ldr_addr;
    logic [7:0]  ldr_wdata;
    logic        ram_ce, ram_wre, ram_oce;
    logic [10:0] ram_ad;
    logic [7:0]  ram_din, ram_dout;

    bootram_ctrl #(.RAM_AW(11)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .ldr_valid (ldr_valid),
        .ldr_ready (ldr_ready),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ram_ce    (ram_ce),
        .ram_wre   (ram_wre),
        .ram_oce   (ram_oce),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Boot RAM macro stand-in: registered read, write-through output.
    logic [7:0] ram_arr [0:2047] = '{default: 8'h00};
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) begin
                ram_arr[ram_ad] <= ram_din;
                ram_dout        <= ram_din;
            end else begin
                ram_dout <= ram_arr[ram_ad];
            end
        end
    end

    // Log of RAM accesses actually enabled, for address/lane checks.
    bit          log_en = 1'b0;
    logic [19:0] acc_log [$];
    always @(posedge clk) begin
        if (log_en && ram_ce) acc_log.push_back({ram_wre, ram_ad, ram_din});
    end

    // Reference model: plain byte array, word = four little-endian bytes.
    logic [7:0] ref_mem [0:2047] = '{default: 8'h00};

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        int unsigned b;
        b = {21'd0, addr[10:2], 2'b00};
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] last_rd = '0;
    int          ldr_pending = 0;
    int          ldr_seen = 0;

    // Monitor: every ready pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && mem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_mem_ready: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.is_rd) begin
                    chk("rdata", mem_rdata, e.data);
                    last_rd = e.data;
                end else begin
                    chk("rdata_hold", mem_rdata, last_rd);
                end
                if (e.lat >= 0) chk("latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
        if (!reset && ldr_ready) begin
            ldr_seen++;
            if (ldr_pending == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ldr_ready: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                ldr_pending--;
            end
        end
    end

    task automatic cpu_issue(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input int lat);
        exp_t        e;
        int unsigned b;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        e.is_rd   = (wstrb == 4'b0000);
        e.issue   = cyc;
        e.lat     = lat;
        e.data    = model_word(addr);
        if (!e.is_rd) begin
            b = {21'd0, addr[10:2], 2'b00};
            for (int unsigned i = 0; i < 4; i++)
                if (wstrb[i]) ref_mem[b+i] = wdata[8*i +: 8];
        end
        exp_q.push_back(e);
    endtask

    task automatic cpu_wait(output int done);
        done = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (mem_ready) begin
                done = cyc;
                break;
            end
        end
        if (done < 0) begin
            checks++;
            errors++;
            $display("FAIL cpu_timeout: got no mem_ready expected one within 64 cycles");
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
    endtask

    task automatic cpu_op(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int lat);
        int d;
        cpu_issue(addr, wdata, wstrb, lat);
        cpu_wait(d);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset   = 1'b0;
        last_rd = '0;
    endtask

`ifdef BOOTRAM_LOADER_EN
    task automatic ldr_issue(input logic [10:0] a, input logic [7:0] d);
        ldr_valid = 1'b1;
        ldr_addr  = a;
        ldr_wdata = d;
        ldr_pending++;
    endtask

    task automatic ldr_wait(output int done);
        done = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (ldr_ready) begin
                done = cyc;
                break;
            end
        end
        if (done < 0) begin
            checks++;
            errors++;
            $display("FAIL ldr_timeout: got no ldr_ready expected one within 64 cycles");
            ldr_pending = 0;
        end
        @(posedge clk);
        #1;
        ldr_valid = 1'b0;
    endtask
`endif

    initial begin
        logic [31:0] wd;
        logic [31:0] a;
        logic [3:0]  s;

        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        ldr_valid = 1'b0;
        ldr_addr  = '0;
        ldr_wdata = '0;

        // Reset held for 3 cycles under random inputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            mem_valid = 1'($urandom);
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_wstrb = 4'($urandom);
            ldr_valid = 1'($urandom);
            ldr_addr  = 11'($urandom);
            ldr_wdata = 8'($urandom);
            @(negedge clk);
            chk("rst_rdata", mem_rdata, '0);
            chk("rst_ctrl", 32'({mem_ready, ldr_ready, ram_ce, ram_wre, ram_oce}), 32'd1);
            chk("rst_bus", 32'({ram_ad, ram_din}), '0);
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_valid = 1'b0;
`ifdef BOOTRAM_LOADER_EN
        ldr_valid = 1'b0;
`else
        ldr_valid = 1'b1;
`endif

        // Full word write, then readback.
        wd = 32'hDEADBEEF;
        acc_log.delete();
        log_en = 1'b1;
        cpu_op(32'h0000_0010, wd, 4'b1111, 5);
        log_en = 1'b0;
        chk("wr_log_len", 32'(acc_log.size()), 32'd4);
        for (int unsigned i = 0; i < 4 && i < acc_log.size(); i++)
            chk("wr_log", 32'(acc_log[i]), 32'({1'b1, 11'(16 + i), wd[8*i +: 8]}));
        cpu_op(32'h0000_0010, '0, 4'b0000, 6);

        // Partial write touches only lane 1.
        acc_log.delete();
        log_en = 1'b1;
        cpu_op(32'h0000_0010, 32'h0000AA00, 4'b0010, 5);
        log_en = 1'b0;
        chk("pw_log_len", 32'(acc_log.size()), 32'd1);
        if (acc_log.size() > 0) chk("pw_log", 32'(acc_log[0]), 32'({1'b1, 11'h011, 8'hAA}));
        cpu_op(32'h0000_0010, '0, 4'b0000, 6);

`ifdef BOOTRAM_LOADER_EN
        begin
            int d1, d2, dl, t0;
            // Tie right after reset: CPU first, then the loader beats the CPU's re-request.
            do_reset(2);
            fork
                begin
                    cpu_issue(32'h0000_0010, '0, 4'b0000, 6);
                    cpu_wait(d1);
                    ref_mem[11'h011] = 8'h55;
                    cpu_issue(32'h0000_0010, '0, 4'b0000, -1);
                    cpu_wait(d2);
                end
                begin
                    ldr_issue(11'h011, 8'h55);
                    ldr_wait(dl);
                end
            join
            chk("tie_ldr_after_cpu", 32'(dl - d1), 32'd3);
            chk("tie_cpu_after_ldr", 32'(d2 - d1), 32'd10);

            // Last grant was the CPU, so this tie goes to the loader.
            ref_mem[11'h012] = 8'h66;
            t0 = cyc;
            fork
                cpu_op(32'h0000_0010, '0, 4'b0000, 9);
                begin
                    ldr_issue(11'h012, 8'h66);
                    ldr_wait(dl);
                end
            join
            chk("tie2_ldr_latency", 32'(dl - t0), 32'd2);
        end
`endif

        // Reset in cycle A+3 of a read: no ready, RAM disabled next cycle.
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0010;
        mem_wstrb = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ce", 32'({ram_ce, mem_ready}), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_valid = 1'b0;
        last_rd   = '0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_rdata", mem_rdata, '0);
        cpu_op(32'h0000_0010, '0, 4'b0000, 6);

        // Randomized CPU traffic, including aliased upper/lower address bits.
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            if (i < 8) a[10:2] = 9'(i);
            else a[10:2] = 9'($urandom_range(0, 15));
            s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
`ifndef BOOTRAM_LOADER_EN
            ldr_addr  = 11'($urandom);
            ldr_wdata = 8'($urandom);
`endif
            cpu_op(a, $urandom, s, (s == 4'b0000) ? 6 : 5);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

`ifndef BOOTRAM_LOADER_EN
        chk("ldr_ready_never", 32'(ldr_seen), 32'd0);
`endif
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
